// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional DIV_ZERO_FLAG_EN: early-out on b==0 with a div_zero flag.
module seq_restoring_divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] S,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic           div_zero
`endif
);

  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t         state;
  logic [2*N-1:0] dvd;
  logic [N-1:0]   dvs;
  logic [N-1:0]   rem;
  logic [CW-1:0]  cnt;
`ifdef DIV_ZERO_FLAG_EN
  logic           dz_pend;
`endif

  logic [N:0]     rem_ext;
  logic           ge;
  logic [N-1:0]   rem_nxt;
  logic [2*N-1:0] dvd_nxt;
  logic           last;

  // dividend register doubles as quotient shifter
  always_comb begin
    rem_ext = {rem, dvd[2*N-1]};
    ge      = rem_ext >= {1'b0, dvs};
    rem_nxt = ge ? (rem_ext[N-1:0] - dvs) : rem_ext[N-1:0];
    dvd_nxt = {dvd[2*N-2:0], ge};
    last    = cnt == CW'(2*N-1);
  end

  assign busy = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz_pend  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd   <= S;
            dvs   <= b;
            rem   <= '0;
            cnt   <= '0;
            state <= RUN;
`ifdef DIV_ZERO_FLAG_EN
            dz_pend  <= b == '0;
            div_zero <= 1'b0;
`endif
          end
        end
        RUN: begin
`ifdef DIV_ZERO_FLAG_EN
          if (dz_pend) begin
            q        <= '1;
            r        <= dvd[N-1:0];
            div_zero <= 1'b1;
            done     <= 1'b1;
            dz_pend  <= 1'b0;
            state    <= FIN;
          end else begin
`else
          begin
`endif
            dvd <= dvd_nxt;
            rem <= rem_nxt;
            cnt <= cnt + 1'b1;
            if (last) begin
              q     <= dvd_nxt;
              r     <= rem_nxt;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed + loopback checks for seq_restoring_divider (N=16).
// Build with DIV_ZERO_FLAG_EN to check the early divide-by-zero path.
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] S;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [15:0] r;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int n_chk = 0;
  int n_fail = 0;

  seq_restoring_divider #(.N(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .S     (S),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [15:0] d;
    logic [31:0] eq;
    logic [15:0] er;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, wait for done (bounded), check pulse width and idle return.
  task automatic run_op(input logic [31:0] s_i, input logic [15:0] b_i,
                        input int exp_lat,
                        output logic [31:0] q_o, output logic [15:0] r_o);
    int lat;
    int busy_lo;
    @(negedge clk);
    S = s_i;
    b = b_i;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    S = ~s_i;
    b = ~b_i;
    lat = 0;
    busy_lo = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_lo++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("busy_during_op", busy_lo, 0);
    chk("busy_at_done", {31'd0, busy}, 1);
    q_o = q;
    r_o = r;
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("idle_after_done", {31'd0, busy}, 0);
  endtask

  vec_t        vecs[$];
  logic [31:0] qv;
  logic [15:0] rv;
  logic [15:0] la, lb;
  int          stray;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    S = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_q", q, 0);
    chk("reset_r", {16'd0, r}, 0);
`ifdef DIV_ZERO_FLAG_EN
    chk("reset_div_zero", {31'd0, div_zero}, 0);
`endif
    rst = 1'b0;

    vecs.push_back('{32'd1000, 16'd7, 32'd142, 16'd6});
    vecs.push_back('{32'hFFFE0001, 16'hFFFF, 32'h0000FFFF, 16'd0});
    vecs.push_back('{32'd5, 16'd9, 32'd0, 16'd5});
    vecs.push_back('{32'hFFFFFFFF, 16'd1, 32'hFFFFFFFF, 16'd0});
    vecs.push_back('{32'hFFFFFFFF, 16'hFFFF, 32'h00010001, 16'd0});
    vecs.push_back('{32'd0, 16'd5, 32'd0, 16'd0});
    vecs.push_back('{32'd100, 16'd100, 32'd1, 16'd0});
    vecs.push_back('{32'h00010000, 16'd3, 32'h00005555, 16'd1});
    vecs.push_back('{32'd99, 16'd100, 32'd0, 16'd99});

    foreach (vecs[i]) begin
      run_op(vecs[i].s, vecs[i].d, 32, qv, rv);
      chk($sformatf("vec%0d_q", i), qv, vecs[i].eq);
      chk($sformatf("vec%0d_r", i), {16'd0, rv}, {16'd0, vecs[i].er});
`ifdef DIV_ZERO_FLAG_EN
      chk($sformatf("vec%0d_dz", i), {31'd0, div_zero}, 0);
`endif
    end

    // loopback against products of nonzero 16-bit operands
    for (int i = 0; i < 10; i++) begin
      la = 16'($urandom_range(1, 65535));
      lb = 16'($urandom_range(1, 65535));
      run_op(32'(la) * 32'(lb), lb, 32, qv, rv);
      chk($sformatf("loop%0d_q", i), qv, {16'd0, la});
      chk($sformatf("loop%0d_r", i), {16'd0, rv}, 0);
    end

    // start while busy is ignored
    @(negedge clk);
    S = 32'd1000;
    b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    S = 32'd50;
    b = 16'd5;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    stray = 12;
    while (!done && stray < 100) begin
      @(posedge clk);
      #1;
      stray++;
    end
    chk("busy_start_lat", stray, 32);
    chk("busy_start_q", q, 32'd142);
    chk("busy_start_r", {16'd0, r}, 32'd6);
    @(posedge clk);
    #1;
    chk("busy_start_idle", {31'd0, busy}, 0);

    // reset mid-operation
    @(negedge clk);
    S = 32'd1000;
    b = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_q", q, 0);
    chk("midrst_r", {16'd0, r}, 0);
    stray = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    chk("midrst_no_stray", stray, 0);
    run_op(32'd1000, 16'd7, 32, qv, rv);
    chk("post_rst_q", qv, 32'd142);
    chk("post_rst_r", {16'd0, rv}, 32'd6);

    // divide by zero
`ifdef DIV_ZERO_FLAG_EN
    run_op(32'h1234ABCD, 16'd0, 1, qv, rv);
    chk("dz_flag", {31'd0, div_zero}, 1);
`else
    run_op(32'h1234ABCD, 16'd0, 32, qv, rv);
`endif
    chk("dz_q", qv, 32'hFFFFFFFF);
    chk("dz_r", {16'd0, rv}, 32'h0000ABCD);
    run_op(32'd5, 16'd9, 32, qv, rv);
    chk("after_dz_q", qv, 32'd0);
    chk("after_dz_r", {16'd0, rv}, 32'd5);
`ifdef DIV_ZERO_FLAG_EN
    chk("dz_cleared", {31'd0, div_zero}, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
